address_sequencer: RTL and testbench

ADDRESS_SEQUENCER -- requirements
Module: address_sequencer

---
 rtl/address_pkg.sv | 25 ++
 rtl/address_sequencer_edge_detector.sv | 28 ++
 rtl/address_sequencer.sv | 90 +++++++++
 tb/tb_address_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/address_pkg.sv
// Shared definitions for the address sequencer: trigger-mode encodings,
// the per-step datapath action and the bank-index width helper.
package address_pkg;

  localparam int MODE_LEVEL = 0;
  localparam int MODE_EDGE  = 1;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_CLEAR,
    ACT_STEP,
    ACT_WRAP
  } action_e;

  // Bank index width: at least one bit, so a single-bank build still has a port.
  function automatic int bank_width(input int count);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < count) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/address_sequencer_edge_detector.sv
// Turns a request input into a one-cycle event, either on its rising edge
// or on every cycle it is high, depending on MODE.
module edge_detector
  import address_pkg::*;
#(
  parameter int MODE = MODE_EDGE
) (
  input  logic I_clk,
  input  logic I_rst,
  input  logic I_in,
  output logic O_evt
);

  logic dly_q;
  logic dly_d;

  always_comb begin
    dly_d = I_in;
    O_evt = (MODE == MODE_EDGE) ? (I_in & ~dly_q) : I_in;
  end

  // Clearing the delayed copy makes an input held through reset count as an edge.
  always_ff @(posedge I_clk) begin
    if (I_rst) dly_q <= 1'b0;
    else       dly_q <= dly_d;
  end

endmodule

// File: rtl/address_sequencer.sv
// Strided address counter with an inclusive upper limit; each wrap returns
// the address to 0, advances the buffer bank and pulses O_wrap.
module address_sequencer
  import address_pkg::*;
#(
  parameter int ADDRESS_BITS = 8,
  parameter int BANK_COUNT   = 2,
  parameter int EDGE_MODE    = 1
) (
  input  logic                               I_clk,
  input  logic                               I_rst,
  input  logic                               I_address_up,
  input  logic                               I_address_reset,
  input  logic [ADDRESS_BITS-1:0]            I_stride,
  input  logic [ADDRESS_BITS-1:0]            I_limit,
  output logic [ADDRESS_BITS-1:0]            O_address,
  output logic [bank_width(BANK_COUNT)-1:0]  O_bank,
  output logic                               O_wrap
);

  localparam int              BANK_W    = bank_width(BANK_COUNT);
  localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(BANK_COUNT - 1);

  logic step_evt;
  logic clr_evt;

  edge_detector #(.MODE(EDGE_MODE)) u_step_det (
    .I_clk (I_clk),
    .I_rst (I_rst),
    .I_in  (I_address_up),
    .O_evt (step_evt)
  );

  edge_detector #(.MODE(EDGE_MODE)) u_clr_det (
    .I_clk (I_clk),
    .I_rst (I_rst),
    .I_in  (I_address_reset),
    .O_evt (clr_evt)
  );

  logic [ADDRESS_BITS-1:0] address_q, address_d;
  logic [BANK_W-1:0]       bank_q, bank_d, bank_next;
  logic                    wrap_q, wrap_d;
  logic [ADDRESS_BITS:0]   sum;
  action_e                 act;

  always_comb begin
    // One extra bit keeps the carry-out, so an overflowing step counts as past the limit.
    sum       = {1'b0, address_q} + {1'b0, I_stride};
    bank_next = (bank_q == BANK_LAST) ? '0 : bank_q + 1'b1;

    act = ACT_HOLD;
    if (clr_evt) begin
      act = ACT_CLEAR;
    end else if (step_evt && (I_stride != '0)) begin
      act = (sum > {1'b0, I_limit}) ? ACT_WRAP : ACT_STEP;
    end

    address_d = address_q;
    bank_d    = bank_q;
    wrap_d    = 1'b0;
    unique case (act)
      ACT_CLEAR: address_d = '0;
      ACT_STEP:  address_d = sum[ADDRESS_BITS-1:0];
      ACT_WRAP: begin
        address_d = '0;
        bank_d    = bank_next;
        wrap_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      address_q <= '0;
      bank_q    <= '0;
      wrap_q    <= 1'b0;
    end else begin
      address_q <= address_d;
      bank_q    <= bank_d;
      wrap_q    <= wrap_d;
    end
  end

  assign O_address = address_q;
  assign O_bank    = bank_q;
  assign O_wrap    = wrap_q;

endmodule

// File: tb/tb_address_sequencer.sv
// Bench for address_sequencer: edge-mode 2-bank, level-mode 3-bank and
// level-mode 1-bank instances, with vector table, corner sequences and a random run.
module tb_address_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_up, a_clr;
  logic [7:0] a_stride, a_limit;
  logic [7:0] a_addr;
  logic [0:0] a_bank;
  logic       a_wrap;

  logic       b_up, b_clr;
  logic [7:0] b_stride, b_limit;
  logic [7:0] b_addr;
  logic [1:0] b_bank;
  logic       b_wrap;
  logic [7:0] c_addr;
  logic [0:0] c_bank;
  logic       c_wrap;

  address_sequencer #(.ADDRESS_BITS(8), .BANK_COUNT(2), .EDGE_MODE(1)) dut_a (
    .I_clk(clk), .I_rst(rst), .I_address_up(a_up), .I_address_reset(a_clr),
    .I_stride(a_stride), .I_limit(a_limit),
    .O_address(a_addr), .O_bank(a_bank), .O_wrap(a_wrap)
  );

  address_sequencer #(.ADDRESS_BITS(8), .BANK_COUNT(3), .EDGE_MODE(0)) dut_b (
    .I_clk(clk), .I_rst(rst), .I_address_up(b_up), .I_address_reset(b_clr),
    .I_stride(b_stride), .I_limit(b_limit),
    .O_address(b_addr), .O_bank(b_bank), .O_wrap(b_wrap)
  );

  address_sequencer #(.ADDRESS_BITS(8), .BANK_COUNT(1), .EDGE_MODE(0)) dut_c (
    .I_clk(clk), .I_rst(rst), .I_address_up(b_up), .I_address_reset(b_clr),
    .I_stride(b_stride), .I_limit(b_limit),
    .O_address(c_addr), .O_bank(c_bank), .O_wrap(c_wrap)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per-instance state updated from the behavioural rules.
  int m_addr [3];
  int m_bank [3];
  int m_wrap [3];
  bit m_pu   [3];
  bit m_pc   [3];

  task automatic model_one(input int i, input bit edge_m, input int banks,
                           input bit up, input bit clr, input int stride, input int limit);
    bit s, c;
    if (rst === 1'b1) begin
      m_addr[i] = 0; m_bank[i] = 0; m_wrap[i] = 0; m_pu[i] = 0; m_pc[i] = 0;
      return;
    end
    s = edge_m ? (up && !m_pu[i]) : up;
    c = edge_m ? (clr && !m_pc[i]) : clr;
    m_pu[i] = up;
    m_pc[i] = clr;
    m_wrap[i] = 0;
    if (c) begin
      m_addr[i] = 0;
    end else if (s && stride != 0) begin
      if (m_addr[i] + stride > limit) begin
        m_addr[i] = 0;
        m_bank[i] = (m_bank[i] + 1) % banks;
        m_wrap[i] = 1;
      end else begin
        m_addr[i] = m_addr[i] + stride;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_one(0, 1'b1, 2, a_up, a_clr, int'(a_stride), int'(a_limit));
    model_one(1, 1'b0, 3, b_up, b_clr, int'(b_stride), int'(b_limit));
    model_one(2, 1'b0, 1, b_up, b_clr, int'(b_stride), int'(b_limit));
  endtask

  task automatic compare_model();
    check("rand_a_addr", a_addr, m_addr[0]);
    check("rand_a_bank", a_bank, m_bank[0]);
    check("rand_a_wrap", a_wrap, m_wrap[0]);
    check("rand_b_addr", b_addr, m_addr[1]);
    check("rand_b_bank", b_bank, m_bank[1]);
    check("rand_b_wrap", b_wrap, m_wrap[1]);
    check("rand_c_addr", c_addr, m_addr[2]);
    check("rand_c_bank", c_bank, 0);
    check("rand_c_wrap", c_wrap, m_wrap[2]);
  endtask

  typedef struct {
    bit         up;
    bit         clr;
    logic [7:0] stride;
    logic [7:0] limit;
    logic [7:0] e_addr;
    bit         e_bank;
    bit         e_wrap;
  } vec_t;

  function automatic vec_t mk(input bit up, input bit clr, input int stride, input int limit,
                              input int e_addr, input bit e_bank, input bit e_wrap);
    vec_t v;
    v.up = up; v.clr = clr; v.stride = 8'(stride); v.limit = 8'(limit);
    v.e_addr = 8'(e_addr); v.e_bank = e_bank; v.e_wrap = e_wrap;
    return v;
  endfunction

  vec_t vt[$];

  initial begin
    rst = 1'b1;
    a_up = 0; a_clr = 0; a_stride = 0; a_limit = 0;
    b_up = 0; b_clr = 0; b_stride = 0; b_limit = 0;

    // stride 1, limit 3: 1,2,3 then wrap to 0
    vt.push_back(mk(1,0,1,3, 1,0,0)); vt.push_back(mk(0,0,1,3, 1,0,0));
    vt.push_back(mk(1,0,1,3, 2,0,0)); vt.push_back(mk(0,0,1,3, 2,0,0));
    vt.push_back(mk(1,0,1,3, 3,0,0)); vt.push_back(mk(0,0,1,3, 3,0,0));
    vt.push_back(mk(1,0,1,3, 0,1,1)); vt.push_back(mk(0,0,1,3, 0,1,0));
    // stride 3, limit 7: 3,6 then 9 > 7 wraps
    vt.push_back(mk(1,0,3,7, 3,1,0)); vt.push_back(mk(0,0,3,7, 3,1,0));
    vt.push_back(mk(1,0,3,7, 6,1,0)); vt.push_back(mk(0,0,3,7, 6,1,0));
    vt.push_back(mk(1,0,3,7, 0,0,1)); vt.push_back(mk(0,0,3,7, 0,0,0));
    // at 5, step and clear together: clear wins
    vt.push_back(mk(1,0,5,7, 5,0,0)); vt.push_back(mk(0,0,5,7, 5,0,0));
    vt.push_back(mk(1,1,5,7, 0,0,0)); vt.push_back(mk(0,0,5,7, 0,0,0));
    // at 6, limit lowered to 4: next step wraps
    vt.push_back(mk(1,0,6,7, 6,0,0)); vt.push_back(mk(0,0,6,7, 6,0,0));
    vt.push_back(mk(1,0,1,4, 0,1,1)); vt.push_back(mk(0,0,1,4, 0,1,0));
    // at 2: zero stride holds, then 0xFF stride carries out
    vt.push_back(mk(1,0,2,255, 2,1,0));   vt.push_back(mk(0,0,2,255, 2,1,0));
    vt.push_back(mk(1,0,0,255, 2,1,0));   vt.push_back(mk(0,0,0,255, 2,1,0));
    vt.push_back(mk(1,0,255,255, 0,0,1)); vt.push_back(mk(0,0,255,255, 0,0,0));
    // plain clear
    vt.push_back(mk(1,0,4,255, 4,0,0)); vt.push_back(mk(0,0,4,255, 4,0,0));
    vt.push_back(mk(0,1,4,255, 0,0,0)); vt.push_back(mk(0,0,4,255, 0,0,0));

    tick();
    tick();
    check("reset_a_addr", a_addr, 0);
    check("reset_a_bank", a_bank, 0);
    check("reset_a_wrap", a_wrap, 0);
    check("reset_b_addr", b_addr, 0);
    check("reset_b_bank", b_bank, 0);
    rst = 1'b0;

    foreach (vt[i]) begin
      a_up = vt[i].up; a_clr = vt[i].clr; a_stride = vt[i].stride; a_limit = vt[i].limit;
      tick();
      check($sformatf("vec%0d_addr", i), a_addr, vt[i].e_addr);
      check($sformatf("vec%0d_bank", i), a_bank, vt[i].e_bank);
      check($sformatf("vec%0d_wrap", i), a_wrap, vt[i].e_wrap);
    end
    a_up = 0; a_clr = 0;

    // eight consecutive wraps bring a two-bank build back to bank 0
    a_stride = 8'd255; a_limit = 8'd0;
    for (int k = 0; k < 8; k++) begin
      a_up = 1; tick();
      check("wrap8_pulse", a_wrap, 1);
      check("wrap8_bank", a_bank, (k + 1) % 2);
      a_up = 0; tick();
      check("wrap8_idle", a_wrap, 0);
    end
    check("wrap8_final_bank", a_bank, 0);

    // input held high for 10 cycles: one step in edge mode, ten in level mode
    a_stride = 8'd1; a_limit = 8'd255; b_stride = 8'd1; b_limit = 8'd255;
    a_up = 1; b_up = 1;
    for (int k = 0; k < 10; k++) tick();
    check("hold_edge_addr", a_addr, 1);
    check("hold_level_addr", b_addr, 10);
    check("hold_level1_addr", c_addr, 10);
    check("hold_level1_bank", c_bank, 0);
    a_up = 0; b_up = 0; tick();

    // reset mid-run with a step rising, then the held input counts as an edge after release
    a_up = 1; a_stride = 8'd255; a_limit = 8'd16; tick();
    check("pre_rst_wrap", a_wrap, 1);
    a_up = 0; tick();
    a_up = 1; a_stride = 8'd5; tick();
    a_up = 0; tick();
    check("pre_rst_addr", a_addr, 5);
    check("pre_rst_bank", a_bank, 1);
    a_up = 1; rst = 1; tick();
    check("rst_a_addr", a_addr, 0);
    check("rst_a_bank", a_bank, 0);
    check("rst_a_wrap", a_wrap, 0);
    check("rst_b_addr", b_addr, 0);
    tick();
    rst = 0; tick();
    check("post_rst_addr", a_addr, 5);
    check("post_rst_wrap", a_wrap, 0);
    tick();
    check("post_rst_hold", a_addr, 5);
    compare_model();

    // randomized run against the reference model
    rst = 1; a_up = 0; a_clr = 0; b_up = 0; b_clr = 0; tick();
    rst = 0;
    a_limit = 8'($urandom_range(0, 255)); b_limit = 8'($urandom_range(0, 255));
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 199) == 0);
      a_up  = 1'($urandom_range(0, 1));
      a_clr = ($urandom_range(0, 19) == 0);
      b_up  = 1'($urandom_range(0, 1));
      b_clr = ($urandom_range(0, 29) == 0);
      a_stride = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4));
      b_stride = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) a_limit = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) b_limit = 8'($urandom_range(0, 255));
      tick();
      compare_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
